// File: rtl/lsu.sv
// Load/store unit: validates one request at a time, issues a single-cycle
// memory access with one-hot size strobes, and returns a registered result or fault.
module lsu #(
  parameter int XLEN      = 32,
  parameter int MEM_BYTES = 4096
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_is_load,
  input  logic            req_is_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_base,
  input  logic [XLEN-1:0] req_offset,
  input  logic [XLEN-1:0] req_store_data,
  input  logic [4:0]      req_rd,
  output logic            mem_enabled,
  output logic            mem_load_enable,
  output logic            mem_store_enable,
  output logic            is_lb,
  output logic            is_lbu,
  output logic            is_lh,
  output logic            is_lhu,
  output logic            is_lw,
  output logic            is_sb,
  output logic            is_sh,
  output logic            is_sw,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_data_in,
  input  logic [XLEN-1:0] mem_data_out,
  output logic            resp_valid,
  output logic [4:0]      resp_rd,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_fault,
  output logic [1:0]      resp_fault_cause
);

  typedef enum logic [2:0] {IDLE, ACCESS, CAPTURE, RESP, FAULT} state_t;

  // Select bit order: lb, lbu, lh, lhu, lw, sb, sh, sw.
  localparam int SEL_LB = 0, SEL_LBU = 1, SEL_LH = 2, SEL_LHU = 3;
  localparam int SEL_LW = 4, SEL_SB = 5, SEL_SH = 6, SEL_SW = 7;

  state_t          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d, sdata_q, sdata_d, rdata_q, rdata_d;
  logic [4:0]      rd_q, rd_d, resp_rd_q, resp_rd_d;
  logic [7:0]      sel_q, sel_d;
  logic            load_q, load_d;
  logic [1:0]      cause_q, cause_d;

  logic [XLEN-1:0] eff_addr;
  logic [7:0]      sel_dec;
  logic            is_half, is_word, illegal, misaligned, out_of_range;
  logic [XLEN:0]   span_m1, last_byte;

  assign eff_addr = req_base + req_offset;

  always_comb begin
    sel_dec = '0;
    if (req_is_load && !req_is_store) begin
      case (req_funct3)
        3'b000:  sel_dec[SEL_LB]  = 1'b1;
        3'b001:  sel_dec[SEL_LH]  = 1'b1;
        3'b010:  sel_dec[SEL_LW]  = 1'b1;
        3'b100:  sel_dec[SEL_LBU] = 1'b1;
        3'b101:  sel_dec[SEL_LHU] = 1'b1;
        default: sel_dec = '0;
      endcase
    end else if (req_is_store && !req_is_load) begin
      case (req_funct3)
        3'b000:  sel_dec[SEL_SB] = 1'b1;
        3'b001:  sel_dec[SEL_SH] = 1'b1;
        3'b010:  sel_dec[SEL_SW] = 1'b1;
        default: sel_dec = '0;
      endcase
    end
  end

  assign is_half    = sel_dec[SEL_LH] | sel_dec[SEL_LHU] | sel_dec[SEL_SH];
  assign is_word    = sel_dec[SEL_LW] | sel_dec[SEL_SW];
  assign illegal    = (sel_dec == 8'd0);
  assign misaligned = (is_half & eff_addr[0]) | (is_word & (eff_addr[1:0] != 2'b00));
  // One extra bit so the last touched byte is compared without wrapping.
  assign span_m1      = is_word ? (XLEN+1)'(3) : (is_half ? (XLEN+1)'(1) : '0);
  assign last_byte    = {1'b0, eff_addr} + span_m1;
  assign out_of_range = (last_byte >= (XLEN+1)'(MEM_BYTES));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    sdata_d   = sdata_q;
    rdata_d   = rdata_q;
    rd_d      = rd_q;
    resp_rd_d = resp_rd_q;
    sel_d     = sel_q;
    load_d    = load_q;
    cause_d   = cause_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = eff_addr;
          sdata_d = req_store_data;
          rd_d    = req_rd;
          sel_d   = sel_dec;
          load_d  = req_is_load;
          if (illegal || misaligned || out_of_range) begin
            state_d   = FAULT;
            cause_d   = illegal ? 2'd3 : (misaligned ? 2'd1 : 2'd2);
            rdata_d   = '0;
            resp_rd_d = req_rd;
            sel_d     = '0;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (load_q) begin
          state_d = CAPTURE;
        end else begin
          state_d   = RESP;
          rdata_d   = '0;
          resp_rd_d = rd_q;
        end
      end
      CAPTURE: begin
        state_d   = RESP;
        rdata_d   = mem_data_out;
        resp_rd_d = rd_q;
      end
      RESP:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      sdata_q   <= '0;
      rdata_q   <= '0;
      rd_q      <= '0;
      resp_rd_q <= '0;
      sel_q     <= '0;
      load_q    <= 1'b0;
      cause_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      sdata_q   <= sdata_d;
      rdata_q   <= rdata_d;
      rd_q      <= rd_d;
      resp_rd_q <= resp_rd_d;
      sel_q     <= sel_d;
      load_q    <= load_d;
      cause_q   <= cause_d;
    end
  end

  // Memory port decodes straight from state so reset drops it without a clock.
  logic in_access;
  assign in_access        = (state_q == ACCESS);
  assign req_ready        = (state_q == IDLE);
  assign mem_enabled      = in_access;
  assign mem_load_enable  = in_access & load_q;
  assign mem_store_enable = in_access & ~load_q;
  assign is_lb            = in_access & sel_q[SEL_LB];
  assign is_lbu           = in_access & sel_q[SEL_LBU];
  assign is_lh            = in_access & sel_q[SEL_LH];
  assign is_lhu           = in_access & sel_q[SEL_LHU];
  assign is_lw            = in_access & sel_q[SEL_LW];
  assign is_sb            = in_access & sel_q[SEL_SB];
  assign is_sh            = in_access & sel_q[SEL_SH];
  assign is_sw            = in_access & sel_q[SEL_SW];
  assign mem_address      = in_access ? addr_q : '0;
  assign mem_data_in      = in_access ? sdata_q : '0;

  assign resp_valid       = (state_q == RESP) || (state_q == FAULT);
  assign resp_fault       = (state_q == FAULT);
  assign resp_fault_cause = (state_q == FAULT) ? cause_q : 2'd0;
  assign resp_rd          = resp_rd_q;
  assign resp_data        = rdata_q;

endmodule

// File: tb/tb_lsu.sv
// Randomized self-checking bench for lsu against a byte-array reference model
// with a simple registered-read memory attached to the memory port.
module tb_lsu;
  localparam int MEMB = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_is_load, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_base, req_offset, req_store_data;
  logic [4:0]  req_rd;
  logic        mem_enabled, mem_load_enable, mem_store_enable;
  logic        is_lb, is_lbu, is_lh, is_lhu, is_lw, is_sb, is_sh, is_sw;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        resp_valid, resp_fault;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic [1:0]  resp_fault_cause;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] env_mem [0:MEMB-1];
  logic [7:0] ref_mem [0:MEMB-1];

  always #5 clk = ~clk;

  lsu #(.XLEN(32), .MEM_BYTES(MEMB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_load(req_is_load), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
    .req_store_data(req_store_data), .req_rd(req_rd),
    .mem_enabled(mem_enabled), .mem_load_enable(mem_load_enable),
    .mem_store_enable(mem_store_enable),
    .is_lb(is_lb), .is_lbu(is_lbu), .is_lh(is_lh), .is_lhu(is_lhu), .is_lw(is_lw),
    .is_sb(is_sb), .is_sh(is_sh), .is_sw(is_sw),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_data(resp_data),
    .resp_fault(resp_fault), .resp_fault_cause(resp_fault_cause)
  );

  // Attached memory: writes on the store strobe, registered extended read.
  function automatic logic [31:0] env_read(input logic [11:0] a);
    logic [31:0] w;
    w = {env_mem[a + 12'd3], env_mem[a + 12'd2], env_mem[a + 12'd1], env_mem[a]};
    if (is_lb)       return {{24{w[7]}}, w[7:0]};
    else if (is_lbu) return {24'd0, w[7:0]};
    else if (is_lh)  return {{16{w[15]}}, w[15:0]};
    else if (is_lhu) return {16'd0, w[15:0]};
    else             return w;
  endfunction

  always @(posedge clk) begin
    if (mem_load_enable) mem_data_out <= env_read(mem_address[11:0]);
    if (mem_store_enable) begin
      env_mem[mem_address[11:0]] = mem_data_in[7:0];
      if (is_sh || is_sw) env_mem[mem_address[11:0] + 12'd1] = mem_data_in[15:8];
      if (is_sw) begin
        env_mem[mem_address[11:0] + 12'd2] = mem_data_in[23:16];
        env_mem[mem_address[11:0] + 12'd3] = mem_data_in[31:24];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference decode: kind indexes {lb,lbu,lh,lhu,lw,sb,sh,sw}.
  function automatic void model(input bit ld, input bit st, input logic [2:0] f3,
                                input logic [31:0] addr,
                                output int cause, output int size, output int kind);
    longint a;
    a = longint'(addr);
    cause = 0; size = 1; kind = 0;
    if (ld == st) cause = 3;
    else if (ld) begin
      case (f3)
        3'd0: begin size = 1; kind = 0; end
        3'd1: begin size = 2; kind = 2; end
        3'd2: begin size = 4; kind = 4; end
        3'd4: begin size = 1; kind = 1; end
        3'd5: begin size = 2; kind = 3; end
        default: cause = 3;
      endcase
    end else begin
      case (f3)
        3'd0: begin size = 1; kind = 5; end
        3'd1: begin size = 2; kind = 6; end
        3'd2: begin size = 4; kind = 7; end
        default: cause = 3;
      endcase
    end
    if (cause == 0) begin
      if (a % size != 0) cause = 1;
      else if (a + size > MEMB) cause = 2;
    end
  endfunction

  task automatic do_req(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] base, input logic [31:0] off,
                        input logic [31:0] sd, input logic [4:0] rd);
    logic [31:0] addr, exp_data, got_data, got_addr, got_din;
    logic [7:0]  got_strb;
    logic [1:0]  got_cause;
    logic        got_fault, got_le, got_se;
    logic [4:0]  got_rd;
    int cause, size, kind, exp_lat, resp_k, resp_cnt, men_cnt, men_k;
    addr = base + off;
    model(ld, st, f3, addr, cause, size, kind);
    exp_data = '0;
    if (cause == 0 && ld) begin
      for (int i = 0; i < size; i++) exp_data[8*i +: 8] = ref_mem[int'(addr) + i];
      if (kind == 0) exp_data = {{24{exp_data[7]}}, exp_data[7:0]};
      if (kind == 2) exp_data = {{16{exp_data[15]}}, exp_data[15:0]};
    end
    exp_lat = (cause != 0) ? 1 : (ld ? 3 : 2);

    @(negedge clk);
    check("ready_before", req_ready, 1);
    req_is_load = ld; req_is_store = st; req_funct3 = f3;
    req_base = base; req_offset = off; req_store_data = sd; req_rd = rd;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    // Scrambled request fields must not disturb the transaction in flight.
    req_base = $urandom; req_offset = $urandom; req_store_data = $urandom;
    req_rd = 5'($urandom); req_funct3 = 3'($urandom);
    req_is_load = 1'($urandom); req_is_store = 1'($urandom);

    resp_k = 0; resp_cnt = 0; men_cnt = 0; men_k = 0;
    got_data = '0; got_addr = '0; got_din = '0; got_strb = '0; got_cause = '0;
    got_fault = 1'b0; got_le = 1'b0; got_se = 1'b0; got_rd = '0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (mem_enabled) begin
        men_cnt++;
        if (men_k == 0) begin
          men_k = k; got_addr = mem_address; got_din = mem_data_in;
          got_le = mem_load_enable; got_se = mem_store_enable;
          got_strb = {is_sw, is_sh, is_sb, is_lw, is_lhu, is_lh, is_lbu, is_lb};
        end
      end
      if (resp_valid) begin
        resp_cnt++;
        if (resp_k == 0) begin
          resp_k = k; got_fault = resp_fault; got_cause = resp_fault_cause;
          got_data = resp_data; got_rd = resp_rd;
        end
      end
      if (k == exp_lat + 1) check("ready_after", req_ready, 1);
    end

    check("resp_latency", resp_k, exp_lat);
    check("resp_count", resp_cnt, 1);
    check("resp_fault", got_fault, (cause != 0) ? 1 : 0);
    check("fault_cause", got_cause, cause);
    check("resp_data", got_data, exp_data);
    check("resp_rd", got_rd, rd);
    check("mem_count", men_cnt, (cause != 0) ? 0 : 1);
    if (cause == 0) begin
      check("mem_cycle", men_k, 1);
      check("strobes", got_strb, 32'd1 << kind);
      check("mem_address", got_addr, addr);
      check("load_en", got_le, ld);
      check("store_en", got_se, st);
      if (st) begin
        check("mem_data_in", got_din, sd);
        for (int i = 0; i < size; i++) ref_mem[int'(addr) + i] = sd[8*i +: 8];
      end
    end
    $display("txn ld=%0d st=%0d f3=%0d addr=0x%08h cause=%0d data=0x%08h rd=%0d",
             ld, st, f3, addr, got_cause, got_data, got_rd);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] legal_f3 [0:4];
    logic [2:0] f3;
    bit ld, st;
    int r;
    legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2;
    legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;
    for (int i = 0; i < MEMB; i++) begin
      env_mem[i] = 8'($urandom);
      ref_mem[i] = env_mem[i];
    end
    env_mem[12'h104] = 8'hEF; env_mem[12'h105] = 8'hBE;
    env_mem[12'h106] = 8'hAD; env_mem[12'h107] = 8'hDE;
    for (int i = 12'h104; i <= 12'h107; i++) ref_mem[i] = env_mem[i];

    rst_n = 1'b0; req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
    req_funct3 = '0; req_base = '0; req_offset = '0; req_store_data = '0; req_rd = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_mem_enabled", mem_enabled, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_fault", resp_fault, 0);
    rst_n = 1'b1;

    do_req(1, 0, 3'd2, 32'h100, 32'h4, 32'h0, 5'd1);
    check("lw_deadbeef", resp_data, 32'hDEADBEEF);
    do_req(0, 1, 3'd0, 32'h200, 32'h0, 32'h123456F0, 5'd2);
    do_req(1, 0, 3'd0, 32'h200, 32'h0, 32'h0, 5'd3);
    check("lb_sext", resp_data, 32'hFFFFFFF0);
    do_req(1, 0, 3'd4, 32'h200, 32'h0, 32'h0, 5'd4);
    check("lbu_zext", resp_data, 32'h000000F0);
    do_req(1, 0, 3'd1, 32'h101, 32'h0, 32'h0, 5'd5);
    do_req(0, 1, 3'd2, 32'h102, 32'h0, 32'h55, 5'd6);
    do_req(1, 0, 3'd2, 32'hFFC, 32'h4, 32'h0, 5'd7);
    do_req(0, 1, 3'd2, 32'hFFC, 32'h0, 32'hCAFEF00D, 5'd8);
    do_req(1, 0, 3'd1, 32'hFFF, 32'h0, 32'h0, 5'd9);
    check("lh_fff_cause", resp_fault_cause, 0);
    do_req(1, 0, 3'd3, 32'h40, 32'h0, 32'h0, 5'd10);
    do_req(1, 1, 3'd2, 32'h40, 32'h0, 32'h0, 5'd11);
    do_req(1, 0, 3'd2, 32'h10, 32'hFFFFFFF0, 32'h0, 5'd12);

    // Reset while a store is in its access cycle: abort with no write or response.
    @(negedge clk);
    req_is_load = 1'b0; req_is_store = 1'b1; req_funct3 = 3'd0;
    req_base = 32'h300; req_offset = 32'h0; req_store_data = ~{24'd0, ref_mem[12'h300]};
    req_rd = 5'd13; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("abort_in_access", mem_store_enable, 1);
    rst_n = 1'b0;
    #1;
    check("abort_mem_enabled", mem_enabled, 0);
    check("abort_store_en", mem_store_enable, 0);
    check("abort_is_sb", is_sb, 0);
    check("abort_mem_address", mem_address, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_no_resp", resp_valid, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready", req_ready, 1);
    do_req(1, 0, 3'd2, 32'h300, 32'h0, 32'h0, 5'd14);

    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 19);
      ld = (r < 10) || (r == 19);
      st = (r >= 10 && r < 18) || (r == 19);
      f3 = ($urandom_range(0, 3) != 0) ? legal_f3[$urandom_range(0, st ? 2 : 4)]
                                       : 3'($urandom);
      if ($urandom_range(0, 3) == 0)
        do_req(ld, st, f3, 32'(MEMB - $urandom_range(0, 8)), 32'($urandom_range(0, 8)),
               $urandom, 5'($urandom));
      else
        do_req(ld, st, f3, 32'($urandom_range(0, MEMB - 1)),
               32'($urandom_range(0, 16)) - 32'd8, $urandom, 5'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/lsu.md
Name: lsu

Overview:
Load/store unit between the execute stage and the byte-addressed data memory. It accepts one memory request at a time, computes the effective address and validates it (funct3 legality, alignment, range). Valid requests become a single-cycle access with one-hot size strobes on the memory port. The unit then returns a registered result or a fault to writeback/trap logic.

Parameters:
XLEN, 32, data and address width.
MEM_BYTES, 4096, memory size in bytes; legal byte addresses are 0 to MEM_BYTES-1.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request offered.
req_ready  out  1  high only in IDLE.
req_is_load  in  1  load request.
req_is_store  in  1  store request.
req_funct3  in  3  RISC-V funct3.
req_base  in  XLEN  rs1 value.
req_offset  in  XLEN  sign-extended immediate.
req_store_data  in  XLEN  rs2 value.
req_rd  in  5  destination register.
mem_enabled  out  1  memory access strobe.
mem_load_enable  out  1  read strobe.
mem_store_enable  out  1  write strobe.
is_lb, is_lbu, is_lh, is_lhu, is_lw, is_sb, is_sh, is_sw  out  1 each  one-hot size/sign select.
mem_address  out  XLEN  effective address.
mem_data_in  out  XLEN  store data.
mem_data_out  in  XLEN  load data, already sign/zero-extended by memory.
resp_valid  out  1  one-cycle result pulse.
resp_rd  out  5  latched rd.
resp_data  out  XLEN  load result; 0 for stores and faults.
resp_fault  out  1  request faulted.
resp_fault_cause  out  2  0 none, 1 misaligned, 2 out of range, 3 illegal.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- States: IDLE, ACCESS, CAPTURE, RESP, FAULT.
- Reset values: state IDLE; req_ready=1; all other outputs 0.
- IDLE:
  - req_ready=1.
  - On req_valid in IDLE, latch the request. Compute addr = req_base + req_offset, truncated mod 2^XLEN.
  - Decode loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Decode stores: 000 sb, 001 sh, 010 sw.
- Checks (fixed priority):
  - Illegal (cause 3): any other funct3, or req_is_load and req_is_store equal.
  - Misaligned (cause 1): half with addr[0]=1, or word with addr[1:0]!=0.
  - Out of range (cause 2): addr + size - 1 >= MEM_BYTES, computed without wrap.
- Fault path: next state FAULT.
  - FAULT: resp_valid=1, resp_fault=1, cause set, resp_data=0, then IDLE.
  - No mem strobe is ever asserted for a faulting request.
- ACCESS (exactly one cycle):
  - mem_enabled=1, plus mem_load_enable or mem_store_enable.
  - Exactly one is_* high; mem_address=addr; mem_data_in=latched store data.
  - Loads go to CAPTURE; stores go to RESP.
- CAPTURE: register mem_data_out into resp_data; go to RESP.
- RESP: resp_valid=1 for one cycle, resp_fault=0; go to IDLE.
- Memory-port outputs decode from state and latched registers, so they drop immediately on reset.
- Latency, with acceptance at edge T:
  - load: ACCESS T+1, resp_valid T+3.
  - store: ACCESS T+1, resp_valid T+2.
  - fault: resp_valid T+1.
- Throughput: next request accepted the cycle after resp_valid.
- Response back-pressure: none; the consumer must take resp_valid when pulsed.
- resp_rd/resp_data hold their value until the next response.
- req_* changes while not in IDLE are ignored.
- Reset mid-operation: abort with no response; strobes low at once; IDLE on release.

Test Plan:
1. Memory bytes 0x104..0x107 = EF BE AD DE. Load funct3=010, base 0x100, offset 4 -> ACCESS one cycle at T+1 with mem_address=0x104 and is_lw; resp_valid at T+3 with resp_data=0xDEADBEEF, resp_fault=0.
2. Store funct3=000, base 0x200, data 0x123456F0 -> is_sb at T+1, resp_valid at T+2 with data 0. Then lb 0x200 returns 0xFFFFFFF0 and lbu 0x200 returns 0x000000F0.
3. Load funct3=001 at 0x101 -> resp_valid at T+1, fault cause 1, mem_enabled never high. Sw at 0x102 -> cause 1.
4. Base 0xFFC, offset 4, lw (addr 0x1000) -> cause 2. Base 0xFFC, offset 0, sw -> succeeds. Lh at 0xFFF -> cause 1, since misaligned beats range.
5. Load funct3=011 -> cause 3. req_is_load=req_is_store=1 -> cause 3. Base 0x10, offset 0xFFFFFFF0, lw -> mem_address=0x0, success.
6. rst_n low during ACCESS of a store -> strobes low immediately, no resp_valid. After release req_ready=1 and a new lw completes normally.
